// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between N_REQ byte producers. In IDLE a winner
// is chosen among the pending requesters and its byte is captured. The byte is
// presented on din_tx with data_update held high until the start bit shows up
// on the monitored tx line. The arbiter then waits for the transmitter's done
// flag to rise and inserts GAP_CYCLES idle cycles before it arbitrates again.
// Everything runs in the clk domain. The UART's own baud clock is not used.
//
// Optional feature (compile-time macro UART_ARB_FIXED_PRIO_EN):
//   defined   : fixed priority, lowest index wins, no round-robin pointer
//   undefined : round-robin starting one past the last served requester
//
// Parameters:
//   N_REQ         number of requesters (2..8)
//   START_TIMEOUT clk cycles allowed from data_update high to start bit
//   GAP_CYCLES    idle cycles after done_tx rise before next arbitration
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   req_valid    [N_REQ]   requester i has a byte pending
//   req_data     [8*N_REQ] byte of requester i in bits [8i+7:8i]
//   req_ready    [N_REQ]   one-cycle accept pulse (byte captured this cycle)
//   din_tx       [8]       byte to the UART transmitter
//   data_update  new-data request to the UART transmitter
//   tx_mon       copy of the UART tx line
//   done_tx      transmitter done flag
//   grant_id     [3]       index of the requester being served
//   busy         high from accept until the gap completes
//   err_timeout  one-cycle pulse when the start bit never appeared
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 1023,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           din_tx,
    output logic                 data_update,
    input  logic                 tx_mon,
    input  logic                 done_tx,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [7:0]     r_din;
    logic [7:0]     w_din_next;
    logic [2:0]     r_grant;
    logic [2:0]     w_grant_next;
    logic           r_busy;
    logic           w_busy_next;
    logic           r_du;
    logic           w_du_next;
    logic           r_err;
    logic           w_err_next;
    logic [TW-1:0]  r_timer;
    logic [TW-1:0]  w_timer_next;
    logic [GW-1:0]  r_gap;
    logic [GW-1:0]  w_gap_next;
    logic           r_done_q;
    logic           w_done_rise;
    logic [N_REQ-1:0] w_ready;
    logic           w_accept;
    logic [SW-1:0]  w_sel;
    logic           w_found;

    // Per-requester byte lanes
    logic [7:0]     w_bytes [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
            assign w_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Only a rising edge of done_tx counts, and only while in SEND
    assign w_done_rise = done_tx & ~r_done_q;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Lowest set index wins: scan downward so the last hit is the lowest
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_sel   = SW'(k);
                w_found = 1'b1;
            end
        end
    end
`else
    logic [SW-1:0]  r_rr;
    logic [SW-1:0]  w_rr_next;
    logic [SW:0]    w_cand;

    // Search upward from the rr pointer with wrap; the candidate index is
    // reduced modulo N_REQ by a single conditional subtract (r_rr+k < 2*N_REQ)
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_rr} + (SW+1)'(k);
            if (w_cand >= (SW+1)'(N_REQ)) begin
                w_cand = w_cand - (SW+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_cand[SW-1:0]]) begin
                w_sel   = w_cand[SW-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_rr_next = (w_sel == SW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_accept) begin
            r_rr <= w_rr_next;
        end
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state_next = r_state;
        w_din_next   = r_din;
        w_grant_next = r_grant;
        w_busy_next  = r_busy;
        w_du_next    = r_du;
        w_err_next   = 1'b0;
        w_timer_next = r_timer;
        w_gap_next   = r_gap;
        w_ready      = '0;
        w_accept     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_accept       = 1'b1;
                    w_ready[w_sel] = 1'b1;
                    w_din_next     = w_bytes[w_sel];
                    w_grant_next   = 3'(w_sel);
                    w_busy_next    = 1'b1;
                    w_du_next      = 1'b1;
                    w_timer_next   = '0;
                    w_state_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!tx_mon) begin
                    w_du_next    = 1'b0;
                    w_state_next = ST_SEND;
                end else if (r_timer == TW'(START_TIMEOUT - 1)) begin
                    // Start bit never came: drop the byte and still observe the gap
                    w_du_next    = 1'b0;
                    w_err_next   = 1'b1;
                    w_gap_next   = '0;
                    w_state_next = ST_GAP;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            ST_SEND: begin
                if (w_done_rise) begin
                    w_gap_next   = '0;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if ((int'(r_gap) + 1) >= GAP_CYCLES) begin
                    w_busy_next  = 1'b0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_next = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_din    <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_du     <= 1'b0;
            r_err    <= 1'b0;
            r_timer  <= '0;
            r_gap    <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_din    <= w_din_next;
            r_grant  <= w_grant_next;
            r_busy   <= w_busy_next;
            r_du     <= w_du_next;
            r_err    <= w_err_next;
            r_timer  <= w_timer_next;
            r_gap    <= w_gap_next;
            r_done_q <= done_tx;
        end
    end

    // The accept pulse is combinational; keep it quiet while reset is applied
    assign req_ready   = rst ? '0 : w_ready;
    assign din_tx      = r_din;
    assign data_update = r_du;
    assign grant_id    = r_grant;
    assign busy        = r_busy;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 15;
    localparam int GAP = 2;
    localparam int BIT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     din_tx;
    logic           data_update;
    logic           tx_mon;
    logic           done_tx;
    logic [2:0]     grant_id;
    logic           busy;
    logic           err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N), .START_TIMEOUT(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .din_tx(din_tx), .data_update(data_update),
        .tx_mon(tx_mon), .done_tx(done_tx), .grant_id(grant_id),
        .busy(busy), .err_timeout(err_timeout)
    );

    // Stimulus state
    logic [N-1:0] vld;
    logic [7:0]   bytes_q [N];
    int           mode;      // 0: drop after accept, 1: hold, 2: random
    logic         stuck;     // transmitter never produces a start bit
    logic [7:0]   uart_byte;

    assign req_valid = vld;
    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = bytes_q[i];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: arbitration ----------------
    typedef struct packed {
        logic [2:0] id;
        logic [7:0] b;
    } exp_t;
    exp_t exp_q[$];
    int   last_served = N - 1;
    int   accepts = 0;

    function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            last_served = N - 1;
        end else if (!busy && vld != '0) begin
            int w;
            exp_t e;
            w = pick(vld, last_served);
            check("accept_onehot", req_ready, 32'(1) << w);
            e.id = 3'(w);
            e.b  = bytes_q[w];
            exp_q.push_back(e);
            last_served = w;
            accepts++;
            $display("accept: requester %0d byte 0x%02h", w, bytes_q[w]);
        end else begin
            check("no_accept", req_ready, 0);
        end
    end

    // ---------------- monitor: transfer, timeout and gap checks ----------------
    logic du_prev = 1'b0, done_prev = 1'b0;
    int   du_run = 0, drop_cnt = -1, err_total = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            du_prev   = 1'b0;
            done_prev = 1'b0;
            du_run    = 0;
            drop_cnt  = -1;
        end else begin
            if (data_update && !du_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_id", grant_id, cur.id);
                    check("din_tx", din_tx, cur.b);
                end
                du_run = 0;
            end
            if (data_update) du_run++;
            if (!data_update && du_prev) begin
                check("din_stable", din_tx, cur.b);
                if (stuck) begin
                    check("timeout_len", du_run, TMO);
                    check("err_pulse", err_timeout, 1);
                end else begin
                    check("no_err", err_timeout, 0);
                    check("start_before_timeout", du_run < TMO, 1);
                end
            end
            if (err_timeout) err_total++;
            if (done_tx && !done_prev && busy && !data_update) begin
                drop_cnt = 0;
            end else if (drop_cnt >= 0) begin
                drop_cnt++;
                if (!busy) begin
                    check("busy_drop", drop_cnt, GAP + 1);
                    drop_cnt = -1;
                end else if (drop_cnt > GAP + 4) begin
                    check("busy_drop", drop_cnt, GAP + 1);
                    drop_cnt = -1;
                end
            end
            du_prev   = data_update;
            done_prev = done_tx;
        end
    end

    // ---------------- UART transmitter model ----------------
    int frames_done = 0;
    initial begin
        tx_mon  = 1'b1;
        done_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (data_update && !stuck) begin
                uart_byte = din_tx;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 tx_mon = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    repeat (BIT) @(posedge clk);
                    #1 tx_mon = uart_byte[b];
                end
                repeat (BIT) @(posedge clk);
                #1 tx_mon = 1'b1;
                repeat (BIT) @(posedge clk);
                #1 done_tx = 1'b1;
                @(posedge clk);
                #1 done_tx = 1'b0;
                frames_done++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (mode == 0) vld[i] = 1'b0;
                else if (mode == 2) begin
                    vld[i]     = 1'($urandom_range(0, 1));
                    bytes_q[i] = 8'($urandom);
                end
            end else if (mode == 2) begin
                if (!vld[i] && $urandom_range(0, 2) == 0) begin
                    vld[i]     = 1'b1;
                    bytes_q[i] = 8'($urandom);
                end else if (vld[i] && $urandom_range(0, 15) == 0) begin
                    vld[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_din_tx"}, din_tx, 0);
        check({tag, "_data_update"}, data_update, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    initial begin
        int k;
        int fd;
        vld   = '0;
        mode  = 0;
        stuck = 1'b0;
        for (int i = 0; i < N; i++) bytes_q[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // All four requesting continuously: rotating order 0x11..0x44
        for (int i = 0; i < N; i++) bytes_q[i] = 8'(8'h11 * (i + 1));
        mode = 1;
        vld  = 4'b1111;
        run(300);
        mode = 0;
        vld  = '0;
        run(60);

        // Single request on requester 1
        bytes_q[1] = 8'hA5;
        vld        = 4'b0010;
        run(60);
        check("single_grant", grant_id, 1);
        check("single_busy_idle", busy, 0);

        // Wrap: serve 2, then 3 and 0 pending
        bytes_q[2] = 8'h3C;
        vld        = 4'b0100;
        run(60);
        bytes_q[3] = 8'hC3;
        bytes_q[0] = 8'h0F;
        vld        = 4'b1001;
        run(100);

        // Start-bit timeout, then a normal request
        stuck      = 1'b1;
        bytes_q[0] = 8'h5A;
        vld        = 4'b0001;
        run(40);
        stuck      = 1'b0;
        bytes_q[1] = 8'h96;
        vld        = 4'b0010;
        run(60);

        // Reset while the frame is on the line
        mode = 1;
        vld  = 4'b1111;
        k    = 0;
        while (tx_mon !== 1'b0 && k < 200) begin
            step();
            k++;
        end
        check("start_bit_seen", k < 200, 1);
        run(3);
        fd   = frames_done;
        rst  = 1'b1;
        mode = 0;
        vld  = '0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        k = 0;
        while (frames_done == fd && k < 100) begin
            step();
            k++;
        end
        check("stale_frame_done", k < 100, 1);
        run(5);
        check("stale_grant", grant_id, 0);
        check("stale_busy", busy, 0);
        bytes_q[2] = 8'h77;
        bytes_q[3] = 8'h88;
        vld        = 4'b1100;
        run(100);

        // Randomized traffic
        mode = 2;
        run(1500);
        mode = 0;
        vld  = '0;
        run(80);

        check("scoreboard_empty", exp_q.size(), 0);
        check("err_total", err_total, 1);
        check("enough_accepts", accepts >= 30, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
